// File: rtl/fifo_rd_checker_pkg.sv
// Shared definitions for the FIFO read-side checker and its write-side generator.
// Holds the state encoding, default sequence constants and counter widths.
package fifo_rd_checker_pkg;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } rd_state_e;

    localparam int unsigned DEF_START_DELAY = 60;
    localparam int unsigned DEF_FIRST_VAL   = 1;
    localparam int unsigned ERR_CNT_W       = 16;
    localparam int unsigned RD_CNT_W        = 32;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rd_checker_if.sv
// FIFO read port: the checker (master) drives the read strobe,
// the FIFO (slave) drives the empty flag and read data.
interface fifo_rd_checker_if #(
    parameter int DATA_W = 16
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en;

    modport master (input  fifo_empty, fifo_dout, output fifo_rd_en);
    modport slave  (output fifo_empty, fifo_dout, input  fifo_rd_en);
endinterface

// File: rtl/seq_cmp.sv
// Sequence comparator: tracks the expected next word, resyncs on every
// checked word and keeps mismatch statistics (count, sticky flag, first bad word).
module seq_cmp
    import fifo_rd_checker_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FIRST_VAL = DEF_FIRST_VAL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_vld,
    input  logic                 i_clr,
    input  logic [DATA_W-1:0]    i_data,
    output logic                 o_err_flag,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic [DATA_W-1:0]    o_first_err
);

    logic [DATA_W-1:0]    r_exp;
    logic                 r_err_flag;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [DATA_W-1:0]    r_first_err;
    logic                 w_mis;

    assign w_mis = i_vld && (i_data != r_exp);

    // Expected value always follows the last checked word, so one bad word
    // counts as a single error rather than cascading.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp <= DATA_W'(FIRST_VAL);
        end else if (i_vld) begin
            r_exp <= i_data + DATA_W'(1);
        end
    end

    // clr wins over the running totals but still records the word checked
    // in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt   <= '0;
            r_err_flag  <= 1'b0;
            r_first_err <= '0;
        end else if (i_clr) begin
            r_err_cnt   <= ERR_CNT_W'(w_mis);
            r_err_flag  <= w_mis;
            r_first_err <= w_mis ? i_data : '0;
        end else if (w_mis) begin
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
            if (!r_err_flag) begin
                r_first_err <= i_data;
            end
            r_err_flag <= 1'b1;
        end
    end

    assign o_err_flag  = r_err_flag;
    assign o_err_cnt   = r_err_cnt;
    assign o_first_err = r_first_err;

endmodule

// File: rtl/fifo_rd_checker.sv
// FIFO read-side checker: waits START_DELAY cycles after reset, then drains the
// FIFO whenever it is non-empty and checks each word is the previous word + 1.
module fifo_rd_checker
    import fifo_rd_checker_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int START_DELAY = DEF_START_DELAY,
    parameter int FIRST_VAL   = DEF_FIRST_VAL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_rd_checker_if.master     fif,
    input  logic                  clr,
    output logic                  data_vld,
    output logic                  err_flag,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [RD_CNT_W-1:0]   rd_cnt,
    output logic [DATA_W-1:0]     first_err
);

    localparam int DLY_W = cnt_w(START_DELAY);

    rd_state_e            r_state;
    rd_state_e            w_state_nxt;
    logic [DLY_W-1:0]     r_dly;
    logic [DLY_W-1:0]     w_dly_nxt;
    logic                 w_rd_en;
    logic                 r_vld;
    logic [RD_CNT_W-1:0]  r_rd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
            r_dly   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dly   <= w_dly_nxt;
        end
    end

    // The read strobe is combinational so an empty FIFO stops reads the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_dly_nxt   = r_dly;
        w_rd_en     = 1'b0;
        case (r_state)
            ST_WAIT: begin
                w_dly_nxt = r_dly + DLY_W'(1);
                if (r_dly == DLY_W'(START_DELAY - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_rd_en = !fif.fifo_empty;
            end
            default: begin
                w_state_nxt = ST_WAIT;
            end
        endcase
    end

    assign fif.fifo_rd_en = w_rd_en;

    // Read data arrives one cycle after the strobe; reset drops any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
        end else begin
            r_vld <= w_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt <= '0;
        end else if (clr) begin
            r_rd_cnt <= RD_CNT_W'(r_vld);
        end else if (r_vld) begin
            r_rd_cnt <= r_rd_cnt + RD_CNT_W'(1);
        end
    end

    seq_cmp #(
        .DATA_W    (DATA_W),
        .FIRST_VAL (FIRST_VAL)
    ) u_seq_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vld       (r_vld),
        .i_clr       (clr),
        .i_data      (fif.fifo_dout),
        .o_err_flag  (err_flag),
        .o_err_cnt   (err_cnt),
        .o_first_err (first_err)
    );

    assign data_vld = r_vld;
    assign rd_cnt   = r_rd_cnt;

endmodule

// File: tb/tb_fifo_rd_checker.sv
// Bench for fifo_rd_checker: a queue-backed FIFO model feeds words, a reference
// model predicts statistics per checked word, and a monitor compares on data_vld.
module tb_fifo_rd_checker;
    import fifo_rd_checker_pkg::*;

    localparam int DW = 16;
    localparam int SD = 60;
    localparam int FV = 1;

    typedef struct {
        int unsigned   rd;
        int unsigned   errs;
        bit            flag;
        logic [DW-1:0] first;
    } sb_t;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          data_vld;
    logic          err_flag;
    logic [15:0]   err_cnt;
    logic [31:0]   rd_cnt;
    logic [DW-1:0] first_err;

    fifo_rd_checker_if #(.DATA_W(DW)) fif ();

    fifo_rd_checker #(
        .DATA_W      (DW),
        .START_DELAY (SD),
        .FIRST_VAL   (FV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fif       (fif),
        .clr       (clr),
        .data_vld  (data_vld),
        .err_flag  (err_flag),
        .err_cnt   (err_cnt),
        .rd_cnt    (rd_cnt),
        .first_err (first_err)
    );

    sb_t           sb_q[$];
    logic [DW-1:0] src[$];
    int            n_chk  = 0;
    int            n_fail = 0;

    // Reference model state (what the statistics should be after each check).
    logic [DW-1:0] m_exp;
    int unsigned   m_rd;
    int unsigned   m_errs;
    bit            m_flag;
    logic [DW-1:0] m_first;
    logic [DW-1:0] gen;

    bit            rd_last;
    logic [DW-1:0] w_last;
    int            cyc, first_rd, first_vld, pulses;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    // Monitor: one cycle after data_vld the counters must match the next prediction.
    initial begin
        bit  pend;
        sb_t e;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("rd_cnt", rd_cnt, e.rd);
                        check("err_cnt", err_cnt, e.errs);
                        check("err_flag", err_flag, e.flag);
                        check("first_err", first_err, e.first);
                    end
                end
                pend = data_vld;
            end
        end
    end

    // One clock of stimulus: apply clr/empty at negedge, model the check for the
    // word read last cycle, take a FIFO read if strobed, present data after the edge.
    task automatic step(input bit want_empty, input bit clr_v);
        @(negedge clk);
        cyc++;
        if (data_vld && first_vld == 0) first_vld = cyc;
        if (clr_v) begin
            m_rd = 0; m_errs = 0; m_flag = 1'b0; m_first = '0;
        end
        if (rd_last) begin
            m_rd++;
            if (w_last != m_exp) begin
                if (m_errs < 65535) m_errs++;
                if (!m_flag) m_first = w_last;
                m_flag = 1'b1;
            end
            m_exp = DW'(32'(w_last) + 32'd1);
            sb_q.push_back('{m_rd, m_errs, m_flag, m_first});
        end
        clr = clr_v;
        fif.fifo_empty = want_empty || (src.size() == 0);
        #1;
        check("rd_en_while_empty", fif.fifo_rd_en && fif.fifo_empty, 0);
        check("rd_en_in_wait", fif.fifo_rd_en && (cyc < SD), 0);
        if (fif.fifo_rd_en && first_rd == 0) first_rd = cyc;
        rd_last = fif.fifo_rd_en;
        if (rd_last) begin
            pulses++;
            w_last = (src.size() > 0) ? src.pop_front() : '0;
        end
        @(posedge clk);
        #1;
        if (rd_last) fif.fifo_dout = w_last;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    task automatic run_src();
        for (int i = 0; i < 2000 && src.size() > 0; i++) step(1'b0, 1'b0);
        check("src_drained", src.size(), 0);
        drain(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        fif.fifo_empty = 1'b0;
        clr = 1'b0;
        #1;
        check("rst_rd_en", fif.fifo_rd_en, 0);
        check("rst_data_vld", data_vld, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_rd_cnt", rd_cnt, 0);
        check("rst_first_err", first_err, 0);
        sb_q.delete();
        src.delete();
        rd_last = 1'b0;
        m_exp = DW'(FV); m_rd = 0; m_errs = 0; m_flag = 1'b0; m_first = '0;
        gen = DW'(FV);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        fif.fifo_empty = 1'b1;
        cyc = 0; first_rd = 0; first_vld = 0; pulses = 0;
    endtask

    initial begin
        logic [DW-1:0] bad;
        logic [DW-1:0] wv;
        rst_n = 1'b0;
        clr = 1'b0;
        fif.fifo_empty = 1'b1;
        fif.fifo_dout = '0;

        // Startup latency and a clean 1..500 run.
        do_reset();
        for (int i = 1; i <= 500; i++) src.push_back(DW'(i));
        run_src();
        check("first_rd_cycle", first_rd, SD);
        check("first_vld_cycle", first_vld, SD + 1);
        check("clean_rd_cnt", rd_cnt, 500);
        check("clean_err_cnt", err_cnt, 0);
        check("clean_err_flag", err_flag, 0);

        // Single gap in the sequence: one error, then resync.
        do_reset();
        foreach (src[i]) src.delete(i);
        src.push_back(DW'(1)); src.push_back(DW'(2)); src.push_back(DW'(3));
        src.push_back(DW'(7)); src.push_back(DW'(8)); src.push_back(DW'(9));
        run_src();
        check("gap_err_cnt", err_cnt, 1);
        check("gap_first_err", first_err, 7);
        check("gap_rd_cnt", rd_cnt, 6);
        check("gap_err_flag", err_flag, 1);

        // Wrap through 0xFFFF -> 0x0000 is not an error.
        src.push_back(16'hFFFD);
        run_src();
        step(1'b1, 1'b1);
        drain(2);
        src.push_back(16'hFFFE); src.push_back(16'hFFFF);
        src.push_back(16'h0000); src.push_back(16'h0001);
        run_src();
        check("wrap_err_cnt", err_cnt, 0);
        check("wrap_err_flag", err_flag, 0);
        check("wrap_rd_cnt", rd_cnt, 4);

        // Empty toggling every other cycle; rd_cnt must match strobes seen.
        step(1'b1, 1'b1);
        drain(1);
        pulses = 0;
        gen = m_exp;
        for (int i = 0; i < 200; i++) begin
            wv = ($urandom_range(0, 9) == 0) ? DW'($urandom) : gen;
            src.push_back(wv);
            gen = DW'(32'(wv) + 32'd1);
        end
        for (int i = 0; i < 1000 && src.size() > 0; i++) step(1'(i % 2), 1'b0);
        check("toggle_drained", src.size(), 0);
        drain(3);
        check("toggle_rd_cnt", rd_cnt, pulses);

        // Random empty/clr/data mix.
        gen = m_exp;
        for (int i = 0; i < 1500; i++) begin
            if (src.size() < 4) begin
                wv = ($urandom_range(0, 9) == 0) ? DW'($urandom) : gen;
                src.push_back(wv);
                gen = DW'(32'(wv) + 32'd1);
            end
            step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 24) == 0));
        end
        drain(3);
        src.delete();

        // clr in the same cycle as a mismatching check.
        bad = DW'(32'(m_exp) + 32'd5);
        src.push_back(bad);
        step(1'b0, 1'b0);
        check("coinc_read", rd_last, 1);
        step(1'b1, 1'b1);
        drain(2);
        check("coinc_rd_cnt", rd_cnt, 1);
        check("coinc_err_cnt", err_cnt, 1);
        check("coinc_err_flag", err_flag, 1);
        check("coinc_first_err", first_err, bad);

        // Reset mid-RUN with a word in flight; the start delay must repeat.
        for (int i = 0; i < 5; i++) src.push_back(DW'(100 + i));
        repeat (3) step(1'b0, 1'b0);
        do_reset();
        for (int i = 1; i <= 10; i++) src.push_back(DW'(i));
        run_src();
        check("rerun_first_rd", first_rd, SD);
        check("rerun_rd_cnt", rd_cnt, 10);
        check("rerun_err_cnt", err_cnt, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_checker.md
FIFO_RD_CHECKER -- requirements
Module: fifo_rd_checker

Interface
REQ-001 Parameter DATA_W, default 16, width of the FIFO read data word.
REQ-002 Parameter START_DELAY, default 60, number of idle clk cycles after reset release before the first read.
REQ-003 Parameter FIRST_VAL, default 1, the first data value expected after reset.
REQ-004 The block SHALL have one clock, clk; reset rst_n is asynchronous and active-low.
REQ-005 clk  input  1  read-side clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 fifo_empty  input  1  FIFO empty flag, synchronous to clk.
REQ-008 fifo_dout  input  DATA_W  FIFO read data, valid one clk cycle after fifo_rd_en.
REQ-009 clr  input  1  single-cycle pulse that clears statistics.
REQ-010 fifo_rd_en  output  1  FIFO read strobe.
REQ-011 data_vld  output  1  high for the cycle in which fifo_dout is checked.
REQ-012 err_flag  output  1  sticky mismatch indicator.
REQ-013 err_cnt  output  16  mismatch count, saturating.
REQ-014 rd_cnt  output  32  checked-word count, wrapping.
REQ-015 first_err  output  DATA_W  fifo_dout value of the first mismatch since reset/clr.

Function
REQ-016 States: WAIT and RUN.
- WAIT: delay counter increments each cycle; at count START_DELAY-1 go to RUN.
- RUN: stays in RUN until reset.
REQ-017 fifo_rd_en SHALL be combinational: (state==RUN) AND NOT fifo_empty.
- It SHALL never be high in WAIT.
- It SHALL never be high while fifo_empty is high.
REQ-018 data_vld SHALL be fifo_rd_en registered by one cycle, for a fixed check latency of one cycle.
REQ-019 On data_vld, fifo_dout SHALL be compared to the expected register exp.
- On a match: exp <= fifo_dout+1.
- On a mismatch: exp <= fifo_dout+1 (resync), err_cnt increments, err_flag <= 1.
REQ-020 exp arithmetic SHALL be modulo 2^DATA_W: expected after 16'hFFFF is 16'h0000, and this is not an error.
REQ-021 rd_cnt SHALL increment on every data_vld and wrap from 2^32-1 to 0.
REQ-022 err_cnt SHALL saturate at 16'hFFFF; err_flag stays 1 until reset or clr.
REQ-023 first_err SHALL capture fifo_dout only on the first mismatch while err_flag is 0.
REQ-024 clr SHALL clear rd_cnt, err_cnt, err_flag and first_err. It SHALL NOT affect state, exp or fifo_rd_en.
REQ-025 If clr and data_vld occur in the same cycle, the counters SHALL reflect only that word:
- rd_cnt = 1;
- err_cnt = 1 on a mismatch, else 0;
- err_flag and first_err are set accordingly.
REQ-026 If fifo_empty rises while in RUN, reads SHALL stop that same cycle. A word already in flight SHALL still be checked.

Reset
REQ-027 While rst_n is low, all outputs SHALL be:
- fifo_rd_en=0, data_vld=0, err_flag=0;
- err_cnt=0, rd_cnt=0, first_err=0.
REQ-028 While rst_n is low: state=WAIT, delay counter=0, exp=FIRST_VAL.
REQ-029 A reset asserted mid-operation SHALL abort immediately. Any in-flight word SHALL be discarded, and the START_DELAY wait SHALL restart after release.

Structure
REQ-030 State encodings and the default FIRST_VAL/START_DELAY constants SHALL live in a shared package also used by the write-side generator.
REQ-031 A sub-module seq_cmp SHALL hold exp, the compare, err_cnt, err_flag and first_err. The top level SHALL hold the state machine, delay counter, read strobe and rd_cnt.

Verification
REQ-032 Reset release, fifo_empty=0 constantly -> fifo_rd_en first high at cycle 60 after release; data_vld one cycle later.
REQ-033 Feed 1,2,3,...,500 -> err_cnt=0, err_flag=0, rd_cnt=500.
REQ-034 Feed 1,2,3,7,8,9 -> err_cnt=1, first_err=7, no further errors, rd_cnt=6.
REQ-035 Feed 16'hFFFE,16'hFFFF,16'h0000,16'h0001 after syncing exp -> no error.
REQ-036 Toggle fifo_empty every other cycle -> fifo_rd_en never high with empty=1; rd_cnt equals the number of rd_en pulses.
REQ-037 clr coincident with a mismatching data_vld -> next cycle rd_cnt=1, err_cnt=1, err_flag=1. Reset mid-RUN -> all outputs 0 and the 60-cycle wait repeats.
